// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared state type and default sizes for the CNN frame scheduler
package cnn_pkg;

  localparam int IMG_PIXELS_DEFAULT = 1024;
  localparam int PIX_W_DEFAULT      = 8;
  localparam int RES_W_DEFAULT      = 48;

  typedef enum logic [2:0] {
    IDLE,
    START,
    STREAM,
    WAIT_RES,
    HOLD_RES
  } sched_state_t;

endpackage

// File: rtl/cnn_result_holder.sv
// rtl/cnn_result_holder.sv - one-entry valid/ready register holding the core result until consumed
module cnn_result_holder
  import cnn_pkg::*;
#(
  parameter int RES_W = RES_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_capture,
  input  logic signed [RES_W-1:0] i_data,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic signed [RES_W-1:0] o_data
);

  logic                    r_valid;
  logic signed [RES_W-1:0] r_data;

  // Data stays put after consumption; only the valid flag is cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_capture) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/cnn_frame_scheduler.sv
// rtl/cnn_frame_scheduler.sv - frame scheduler in front of the CNN core; optional result timeout via CNN_SCHED_TIMEOUT_EN
module cnn_frame_scheduler
  import cnn_pkg::*;
#(
  parameter int IMG_PIXELS     = IMG_PIXELS_DEFAULT,
  parameter int PIX_W          = PIX_W_DEFAULT,
  parameter int RES_W          = RES_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_enable,
  input  logic                    s_pix_valid,
  input  logic [PIX_W-1:0]        s_pix_data,
  output logic                    s_pix_ready,
  output logic                    core_start,
  output logic                    core_pix_valid,
  output logic [PIX_W-1:0]        core_pix_data,
  input  logic                    core_res_valid,
  input  logic signed [RES_W-1:0] core_res_data,
  output logic                    m_res_valid,
  output logic signed [RES_W-1:0] m_res_data,
  input  logic                    m_res_ready,
  output logic                    o_busy,
  output logic [15:0]             o_frame_cnt,
  output logic                    o_timeout
);

  localparam int CNT_W = $clog2(IMG_PIXELS + 1);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("cnn_frame_scheduler: TIMEOUT_CYCLES must be at least 1");
  end

  sched_state_t     r_state;
  sched_state_t     w_next;
  logic             r_busy;
  logic [CNT_W-1:0] r_pix_cnt;
  logic             r_pix_valid;
  logic [PIX_W-1:0] r_pix_data;
  logic [15:0]      r_frame_cnt;

  logic w_start;
  logic w_pix_ready;
  logic w_capture;
  logic w_pix_hs;
  logic w_last_pix;
  logic w_res_valid;
  logic w_res_hs;
  logic w_timeout_hit;

  assign w_pix_hs   = s_pix_valid & w_pix_ready;
  assign w_last_pix = w_pix_hs && (r_pix_cnt == CNT_W'(IMG_PIXELS - 1));
  assign w_res_hs   = w_res_valid & m_res_ready;

  // State register; busy is registered from the next state so it tracks the state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (i_enable) w_next = START;
      START:    w_next = STREAM;
      STREAM:   if (w_last_pix) w_next = WAIT_RES;
      WAIT_RES: begin
        if (core_res_valid)     w_next = HOLD_RES;
        else if (w_timeout_hit) w_next = IDLE;
      end
      HOLD_RES: if (w_res_hs) w_next = i_enable ? START : IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    w_start     = (r_state == START);
    w_pix_ready = (r_state == STREAM);
    w_capture   = (r_state == WAIT_RES) && core_res_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
      r_pix_cnt   <= '0;
    end else begin
      r_pix_valid <= w_pix_hs;
      if (w_pix_hs) begin
        r_pix_data <= s_pix_data;
        r_pix_cnt  <= r_pix_cnt + 1'b1;
      end else if (w_start) begin
        r_pix_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_res_hs) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

`ifdef CNN_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;

  // A result arriving on the final count takes priority over the timeout.
  assign w_timeout_hit = (r_state == WAIT_RES) && !core_res_valid &&
                         (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if ((r_state == WAIT_RES) && !core_res_valid && !w_timeout_hit) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
        r_to_cnt <= '0;
      end
      if (w_timeout_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_timeout_hit = 1'b0;
  assign o_timeout     = 1'b0;
`endif

  cnn_result_holder #(
    .RES_W (RES_W)
  ) u_result_holder (
    .clk       (clk),
    .rst       (rst),
    .i_capture (w_capture),
    .i_data    (core_res_data),
    .i_ready   (m_res_ready),
    .o_valid   (w_res_valid),
    .o_data    (m_res_data)
  );

  assign s_pix_ready    = w_pix_ready;
  assign core_start     = w_start;
  assign core_pix_valid = r_pix_valid;
  assign core_pix_data  = r_pix_data;
  assign m_res_valid    = w_res_valid;
  assign o_busy         = r_busy;
  assign o_frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_cnn_frame_scheduler.sv
// tb/tb_cnn_frame_scheduler.sv - directed/randomized frame sequence against a queue-based reference model
module tb_cnn_frame_scheduler;

  localparam int N     = 1024;
  localparam int PIX_W = 8;
  localparam int RES_W = 48;
  localparam int TO    = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    i_enable;
  logic                    s_pix_valid;
  logic [PIX_W-1:0]        s_pix_data;
  logic                    s_pix_ready;
  logic                    core_start;
  logic                    core_pix_valid;
  logic [PIX_W-1:0]        core_pix_data;
  logic                    core_res_valid;
  logic signed [RES_W-1:0] core_res_data;
  logic                    m_res_valid;
  logic signed [RES_W-1:0] m_res_data;
  logic                    m_res_ready;
  logic                    o_busy;
  logic [15:0]             o_frame_cnt;
  logic                    o_timeout;

  int n_pass  = 0;
  int n_total = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  cnn_frame_scheduler #(
    .IMG_PIXELS     (N),
    .PIX_W          (PIX_W),
    .RES_W          (RES_W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_enable       (i_enable),
    .s_pix_valid    (s_pix_valid),
    .s_pix_data     (s_pix_data),
    .s_pix_ready    (s_pix_ready),
    .core_start     (core_start),
    .core_pix_valid (core_pix_valid),
    .core_pix_data  (core_pix_data),
    .core_res_valid (core_res_valid),
    .core_res_data  (core_res_data),
    .m_res_valid    (m_res_valid),
    .m_res_data     (m_res_data),
    .m_res_ready    (m_res_ready),
    .o_busy         (o_busy),
    .o_frame_cnt    (o_frame_cnt),
    .o_timeout      (o_timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_pix_ready"}, 64'(s_pix_ready), 64'd0);
    check({tag, "_core_start"}, 64'(core_start), 64'd0);
    check({tag, "_core_pix_valid"}, 64'(core_pix_valid), 64'd0);
    check({tag, "_core_pix_data"}, 64'(core_pix_data), 64'd0);
    check({tag, "_m_res_valid"}, 64'(m_res_valid), 64'd0);
    check({tag, "_m_res_data"}, 64'(m_res_data), 64'd0);
    check({tag, "_o_busy"}, 64'(o_busy), 64'd0);
    check({tag, "_o_frame_cnt"}, 64'(o_frame_cnt), 64'd0);
    check({tag, "_o_timeout"}, 64'(o_timeout), 64'd0);
  endtask

  // mode: 0 no bubbles, 1 valid every other cycle, 2 random bubbles.
  // lat < 0: core never answers. abort_at > 0: async reset after that many pixels.
  task automatic run_frame(input int mode, input logic signed [RES_W-1:0] res, input int lat,
                           input int bp, input bit spur, input bit en_after, input int abort_at);
    logic [PIX_W-1:0] pix [$];
    logic [PIX_W-1:0] seen [$];
    int sent, starts, cyc, bad;
    bit spur_done;
    for (int i = 0; i < N; i++) pix.push_back(PIX_W'($urandom));
    sent = 0; starts = 0; cyc = 0; bad = 0; spur_done = 0;

    i_enable = 1'b1;
    while (!core_start && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("start_seen", 64'(core_start), 64'd1);
    check("busy_in_start", 64'(o_busy), 64'd1);
    i_enable = 1'b0;

    cyc = 0;
    while (sent < N && cyc < 4 * N && !(abort_at > 0 && sent >= abort_at)) begin
      if (core_pix_valid) seen.push_back(core_pix_data);
      if (core_start) starts++;
      case (mode)
        0:       s_pix_valid = 1'b1;
        1:       s_pix_valid = (cyc % 2 == 0);
        default: s_pix_valid = ($urandom_range(0, 3) != 0);
      endcase
      s_pix_data = pix[sent];
      core_res_valid = spur && !spur_done && (sent >= N / 2);
      core_res_data  = RES_W'({$urandom, $urandom});
      if (core_res_valid) spur_done = 1'b1;
      if (s_pix_valid && s_pix_ready) sent++;
      @(negedge clk);
      cyc++;
    end
    s_pix_valid    = 1'b0;
    core_res_valid = 1'b0;

    if (abort_at > 0) begin
      check("abort_reached", 64'(sent), 64'(abort_at));
      #2 rst = 1'b1;
      #1 check_all_zero("async_rst");
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 0;
      return;
    end

    check("stream_done", 64'(sent), 64'(N));
    check("ready_drop", 64'(s_pix_ready), 64'd0);
    if (core_pix_valid) seen.push_back(core_pix_data);
    check("start_pulses", 64'(starts), 64'd1);
    check("beat_count", 64'(seen.size()), 64'(N));
    for (int i = 0; i < N && i < seen.size(); i++) if (seen[i] !== pix[i]) bad++;
    check("beat_data", 64'(bad), 64'd0);

    if (lat < 0) begin
`ifdef CNN_SCHED_TIMEOUT_EN
      for (int k = 1; k <= TO; k++) begin
        @(negedge clk);
        if (k == TO - 1) check("timeout_early", 64'(o_timeout), 64'd0);
      end
      check("timeout_set", 64'(o_timeout), 64'd1);
      check("timeout_idle", 64'(o_busy), 64'd0);
      check("timeout_no_res", 64'(m_res_valid), 64'd0);
      check("timeout_cnt", 64'(o_frame_cnt), 64'(exp_cnt));
`endif
      return;
    end

    bad = 0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (m_res_valid || s_pix_ready || core_pix_valid || !o_busy) bad++;
    end
    check("wait_quiet", 64'(bad), 64'd0);
    core_res_valid = 1'b1;
    core_res_data  = res;
    @(negedge clk);
    core_res_valid = 1'b0;
    core_res_data  = RES_W'({$urandom, $urandom});
    check("res_valid", 64'(m_res_valid), 64'd1);
    check("res_data", 64'(m_res_data), 64'(res));
    check("cnt_before_hs", 64'(o_frame_cnt), 64'(exp_cnt));

    bad = 0;
    m_res_ready = 1'b0;
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      if (m_res_valid !== 1'b1 || m_res_data !== res || o_frame_cnt !== 16'(exp_cnt)) bad++;
    end
    check("hold_stable", 64'(bad), 64'd0);

    i_enable    = en_after;
    m_res_ready = 1'b1;
    @(negedge clk);
    m_res_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 65536;
    check("cnt_after_hs", 64'(o_frame_cnt), 64'(exp_cnt));
    check("res_released", 64'(m_res_valid), 64'd0);
    check("next_start", 64'(core_start), 64'(en_after));
    check("busy_after_hs", 64'(o_busy), 64'(en_after));
  endtask

  initial begin
    logic signed [RES_W-1:0] r;
    rst = 1'b1; i_enable = 1'b0; s_pix_valid = 1'b0; s_pix_data = '0;
    core_res_valid = 1'b0; core_res_data = '0; m_res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_enable", 64'(o_busy), 64'd0);

    run_frame(0, -48'sd12345, 100, 0, 1'b0, 1'b0, 0);
    r = RES_W'({$urandom, $urandom});
    run_frame(1, r, 7, 0, 1'b0, 1'b0, 0);
    r = RES_W'({$urandom, $urandom});
    run_frame(2, r, 20, 50, 1'b1, 1'b1, 0);
    r = RES_W'({$urandom, $urandom});
    run_frame(2, r, 3, 5, 1'b0, 1'b0, 0);
`ifdef CNN_SCHED_TIMEOUT_EN
    run_frame(0, '0, -1, 0, 1'b0, 1'b0, 0);
`else
    check("timeout_tied_low", 64'(o_timeout), 64'd0);
`endif
    r = RES_W'({$urandom, $urandom});
    run_frame(2, r, 5, 0, 1'b0, 1'b0, 500);
    r = RES_W'({$urandom, $urandom});
    run_frame(0, r, 10, 0, 1'b0, 1'b0, 0);
    check("cnt_after_reset_frame", 64'(o_frame_cnt), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
